conv_mac_lanes: RTL and testbench
=================================

Name: conv_mac_lanes

Overview:
Multi-lane, back-pressured successor to the single-lane streaming convolution MAC. Each accepted beat carries LANES operand pairs. The per-beat dot product goes through a registered product stage and an adder tree, and is accumulated over a window delimited by in_first/in_last. Each finished window is pushed into an output FIFO drained with a valid/ready handshake, with selectable wrap or saturate output and an overflow flag. It sits between the window-gather logic and the activation/writeback stage.

Parameters:
WIDTH, 8, element bit-width of each a/b lane
LANES, 4, operand pairs per beat (power of two, 1..16)
ACC_WIDTH, 32, output sum width
GUARD, 8, extra internal accumulator bits; internal width IW = ACC_WIDTH+GUARD
SIGNED_MUL, 1, 1: a, b and bias are signed; 0: unsigned
SAT_MODE, 1, 1: saturate out_sum to ACC_WIDTH; 0: truncate (wrap)
OUT_DEPTH, 2, result FIFO depth (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  beat offered
in_ready  out  1  beat accepted when in_valid && in_ready
in_first  in  1  first beat of window
in_last  in  1  last beat of window
in_keep  in  LANES  per-lane enable; a 0 lane contributes 0
a_in  in  LANES*WIDTH  lane i at [i*WIDTH +: WIDTH]
b_in  in  LANES*WIDTH  same packing as a_in
bias_valid  in  1  add bias_in once, on the in_first beat only
bias_in  in  ACC_WIDTH  bias value
out_valid  out  1  result available
out_ready  in  1  result consumed when out_valid && out_ready
out_sum  out  ACC_WIDTH  window result
out_ovf  out  1  result saturated or wrapped (qualified by out_valid)
err_pulse  out  1  one-cycle pulse on protocol error

Behaviour:
- Reset (rst high at an edge): clears FIFO, pipeline valids and accumulator; clears the window-open flag. out_valid=0, out_ovf=0, err_pulse=0, out_sum=0. in_ready=1 from the first cycle after reset. rst has priority over every other event.
- Stage 1 (edge after acceptance): register LANES products (2*WIDTH bits), signed or unsigned per SIGNED_MUL. Masked lanes register 0. Also register first, last, bias and bias_valid.
- Stage 2 (next edge): extend products to IW and sum with a combinational adder tree.
  - If first: acc <= tree + (bias_valid ? ext(bias) : 0).
  - Otherwise: acc <= acc + tree.
  - ext is sign-extension if SIGNED_MUL, else zero-extension. All internal arithmetic wraps at IW bits.
- Result: when a last beat completes stage 2, the final IW-bit value is converted and pushed into the FIFO in the same edge.
  - SAT_MODE=1: clamp to the ACC_WIDTH range (signed or unsigned per SIGNED_MUL); ovf=1 if clamped.
  - SAT_MODE=0: take the low ACC_WIDTH bits; ovf=1 if the discarded bits are not a pure extension.
- Latency: last beat accepted at edge k, result written at edge k+2, out_valid=1 in the cycle after edge k+2 when the FIFO was empty. Throughput: 1 beat/cycle.
- Admission: in_ready = (fifo_count + in-flight last beats in stages 1..2) < OUT_DEPTH. in_ready depends only on registered state, with no combinational path from in_valid. The pipeline never stalls, so the FIFO never overflows.
- Output: FIFO is first-word-fall-through. out_sum/out_ovf are stable while out_valid && !out_ready. Push and pop may occur in the same cycle; occupancy is then unchanged.
- Window tracking (at acceptance):
  - in_first while a window is open: err_pulse; the partial window is discarded and the new window starts.
  - A beat with in_first=0 while no window is open: err_pulse; treated as in_first=1 with bias ignored.
  - in_first && in_last together: single-beat window.
  - bias_valid without in_first: ignored.
- Beats with in_valid=0, or in_valid=1 with in_ready=0, have no effect.
- Reset mid-window or with a full FIFO: all partial and buffered results are lost; no out_valid until new complete windows arrive.

Test Plan:
1. LANES=4, signed. Beat1 first a={1,2,3,4} b={1,1,1,1}; beat2 last a={-1,-1,-1,-1} b={2,2,2,2}, keep=4'hF -> out_sum=2, out_ovf=0, out_valid 3 cycles after beat2 is accepted.
2. Single beat first&last, bias_valid=1, bias=100, a={10,0,0,0} b={5,0,0,0}, keep=4'b0001 -> out_sum=150. Same stimulus with keep=0 -> out_sum=100.
3. OUT_DEPTH=2, out_ready=0, stream three 1-beat windows -> in_ready drops after the second window is accepted; the third waits. Raise out_ready -> results emerge in order with none lost or duplicated.
4. ACC_WIDTH=16, SAT_MODE=1, signed, 8 beats of a=b=127 on all 4 lanes -> out_sum=32767, out_ovf=1. Same with SAT_MODE=0 -> out_sum=516128 mod 2^16 reinterpreted as signed, out_ovf=1.
5. in_first arrives mid-window -> err_pulse for exactly 1 cycle; only the new window's sum is output.
6. Assert rst during the second beat of an open window with one result buffered -> out_valid=0 next cycle, in_ready=1. A following clean window produces the correct sum.

Source files
------------

// File: rtl/conv_mac_lanes_if.sv
// conv_mac_lanes_if: beat input stream and result output stream of conv_mac_lanes
interface conv_mac_lanes_if #(
  parameter int WIDTH = 8,
  parameter int LANES = 4,
  parameter int ACC_WIDTH = 32
);
  logic in_valid;
  logic in_ready;
  logic in_first;
  logic in_last;
  logic [LANES-1:0] in_keep;
  logic [LANES*WIDTH-1:0] a_in;
  logic [LANES*WIDTH-1:0] b_in;
  logic bias_valid;
  logic [ACC_WIDTH-1:0] bias_in;
  logic out_valid;
  logic out_ready;
  logic [ACC_WIDTH-1:0] out_sum;
  logic out_ovf;
  logic err_pulse;
  modport master (
    output in_valid, in_first, in_last, in_keep, a_in, b_in, bias_valid, bias_in, out_ready,
    input in_ready, out_valid, out_sum, out_ovf, err_pulse
  );
  modport slave (
    input in_valid, in_first, in_last, in_keep, a_in, b_in, bias_valid, bias_in, out_ready,
    output in_ready, out_valid, out_sum, out_ovf, err_pulse
  );
endinterface

// File: rtl/conv_mac_lanes.sv
// conv_mac_lanes: multi-lane windowed dot-product MAC feeding a first-word-fall-through result FIFO
module conv_mac_lanes #(
  parameter int WIDTH = 8,
  parameter int LANES = 4,
  parameter int ACC_WIDTH = 32,
  parameter int GUARD = 8,
  parameter int SIGNED_MUL = 1,
  parameter int SAT_MODE = 1,
  parameter int OUT_DEPTH = 2
) (
  input logic clk,
  input logic rst,
  conv_mac_lanes_if.slave bus
);
  localparam int IW = ACC_WIDTH + GUARD;
  localparam int PD = 2 * WIDTH;
  localparam int PW = OUT_DEPTH > 1 ? $clog2(OUT_DEPTH) : 1;
  localparam int CW = $clog2(OUT_DEPTH + 1) + 1;
  localparam logic [PW-1:0] LAST = PW'(OUT_DEPTH - 1);
  localparam bit SGN = SIGNED_MUL != 0;
  logic accept, push, pop, fits;
  logic s0_v, s0_first, s0_last, s0_bv, open, err_q;
  logic s1_v, s1_first, s1_last, s1_bv;
  logic [LANES-1:0] s0_keep;
  logic [LANES*WIDTH-1:0] s0_a, s0_b;
  logic [ACC_WIDTH-1:0] s0_bias, s1_bias, sat_val, res;
  logic [PD-1:0] prod [LANES];
  logic [IW-1:0] acc, tree, nxt;
  logic [ACC_WIDTH:0] mem [OUT_DEPTH];
  logic [PW-1:0] wr, rd;
  logic [CW-1:0] cnt;

  function automatic logic [PD-1:0] widen(input logic [WIDTH-1:0] x);
    return {{WIDTH{SGN && x[WIDTH-1]}}, x};
  endfunction

  assign accept = bus.in_valid && bus.in_ready;
  // Reserve a FIFO slot for every window-closing beat still in flight so the pipeline never stalls
  assign bus.in_ready = cnt + CW'(s0_v && s0_last) + CW'(s1_v && s1_last) < CW'(OUT_DEPTH);

  always_ff @(posedge clk) begin
    if (rst) begin
      s0_v <= 1'b0;
      open <= 1'b0;
      err_q <= 1'b0;
    end else begin
      s0_v <= accept;
      err_q <= accept && (bus.in_first == open);
      if (accept) open <= !bus.in_last;
    end
    if (accept) begin
      s0_first <= bus.in_first || !open;
      s0_last <= bus.in_last;
      s0_bv <= bus.bias_valid && bus.in_first;
      s0_keep <= bus.in_keep;
      s0_a <= bus.a_in;
      s0_b <= bus.b_in;
      s0_bias <= bus.bias_in;
    end
  end

  always_ff @(posedge clk) begin
    s1_v <= !rst && s0_v;
    s1_first <= s0_first;
    s1_last <= s0_last;
    s1_bv <= s0_bv;
    s1_bias <= s0_bias;
    for (int i = 0; i < LANES; i++)
      prod[i] <= s0_keep[i] ? widen(s0_a[i*WIDTH +: WIDTH]) * widen(s0_b[i*WIDTH +: WIDTH]) : '0;
  end

  always_comb begin
    tree = '0;
    for (int i = 0; i < LANES; i++) tree = tree + {{(IW-PD){SGN && prod[i][PD-1]}}, prod[i]};
    nxt = s1_first ? tree + (s1_bv ? {{GUARD{SGN && s1_bias[ACC_WIDTH-1]}}, s1_bias} : '0) : acc + tree;
  end

  assign fits = SGN ? (&nxt[IW-1:ACC_WIDTH-1] || ~|nxt[IW-1:ACC_WIDTH-1]) : ~|nxt[IW-1:ACC_WIDTH];
  assign sat_val = SGN ? {nxt[IW-1], {(ACC_WIDTH-1){!nxt[IW-1]}}} : '1;
  assign res = (SAT_MODE != 0 && !fits) ? sat_val : nxt[ACC_WIDTH-1:0];
  assign push = s1_v && s1_last;
  assign pop = bus.out_valid && bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      wr <= '0;
      rd <= '0;
      cnt <= '0;
    end else begin
      if (s1_v) acc <= nxt;
      if (push) wr <= wr == LAST ? '0 : wr + 1'b1;
      if (pop) rd <= rd == LAST ? '0 : rd + 1'b1;
      cnt <= cnt + CW'(push) - CW'(pop);
    end
    if (push) mem[wr] <= {!fits, res};
  end

  assign bus.out_valid = |cnt;
  assign bus.out_sum = bus.out_valid ? mem[rd][ACC_WIDTH-1:0] : '0;
  assign bus.out_ovf = bus.out_valid && mem[rd][ACC_WIDTH];
  assign bus.err_pulse = err_q;
endmodule

// File: tb/tb_conv_mac_lanes.sv
// tb_conv_mac_lanes: three DUT widths/modes driven in lockstep and checked against a window-sum model
module tb_conv_mac_lanes;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  conv_mac_lanes_if #(.ACC_WIDTH(32)) m ();
  conv_mac_lanes_if #(.ACC_WIDTH(16)) s16 ();
  conv_mac_lanes_if #(.ACC_WIDTH(16)) w16 ();

  assign {s16.in_valid, s16.in_first, s16.in_last, s16.in_keep, s16.a_in, s16.b_in, s16.bias_valid, s16.out_ready} =
         {m.in_valid, m.in_first, m.in_last, m.in_keep, m.a_in, m.b_in, m.bias_valid, m.out_ready};
  assign {w16.in_valid, w16.in_first, w16.in_last, w16.in_keep, w16.a_in, w16.b_in, w16.bias_valid, w16.out_ready} =
         {m.in_valid, m.in_first, m.in_last, m.in_keep, m.a_in, m.b_in, m.bias_valid, m.out_ready};
  assign s16.bias_in = m.bias_in[15:0];
  assign w16.bias_in = m.bias_in[15:0];

  conv_mac_lanes u_main (.clk(clk), .rst(rst), .bus(m));
  conv_mac_lanes #(.ACC_WIDTH(16), .SAT_MODE(1)) u_sat (.clk(clk), .rst(rst), .bus(s16));
  conv_mac_lanes #(.ACC_WIDTH(16), .SAT_MODE(0)) u_wrap (.clk(clk), .rst(rst), .bus(w16));

  int checks = 0;
  int errors = 0;
  int pops = 0;
  longint exp_q[$];
  bit win_open = 1'b0;
  longint acc_m = 0;
  bit hold = 1'b0;
  logic [31:0] held;
  longint mon_v;
  bit mon_o;
  bit done;

  typedef struct {
    logic [3:0] keep;
    logic [31:0] a;
    logic [31:0] b;
    bit bv;
    int bias;
    int sum;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(string name, longint act, longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  function automatic longint lowbits(longint v, int n);
    return v & ((64'sd1 <<< n) - 1);
  endfunction

  function automatic longint conv(longint v, int aw, bit sat, output bit ovf);
    longint mx = (64'sd1 <<< (aw - 1)) - 1;
    ovf = v > mx || v < -mx - 1;
    return lowbits((sat && ovf) ? (v > 0 ? mx : -mx - 1) : v, aw);
  endfunction

  // Exact window sums from the beat rules; no width effects until conversion
  function automatic void model(bit first, bit last, bit bv, logic [3:0] keep, logic [31:0] a, logic [31:0] b,
                                int bias, output bit err);
    longint dot = 0;
    for (int i = 0; i < 4; i++)
      if (keep[i]) dot += longint'($signed(a[i*8 +: 8])) * longint'($signed(b[i*8 +: 8]));
    err = (first && win_open) || (!first && !win_open);
    if (first || !win_open) acc_m = (first && bv) ? longint'(bias) : 0;
    acc_m += dot;
    win_open = !last;
    if (last) exp_q.push_back(acc_m);
  endfunction

  always @(negedge clk) begin
    if (!rst && hold && m.out_valid) chk("stable out_sum", longint'(m.out_sum), longint'(held));
    hold = !rst && m.out_valid && !m.out_ready;
    held = m.out_sum;
    if (!rst && m.out_valid && m.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected result: got %0d expected none", m.out_sum);
      end else begin
        mon_v = exp_q.pop_front();
        pops++;
        chk("main sum", longint'(m.out_sum), conv(mon_v, 32, 1'b1, mon_o));
        chk("main ovf", longint'(m.out_ovf), longint'(mon_o));
        chk("sat16 sum", longint'(s16.out_sum), conv(mon_v, 16, 1'b1, mon_o));
        chk("sat16 ovf", longint'(s16.out_ovf), longint'(mon_o));
        chk("wrap16 sum", longint'(w16.out_sum), conv(mon_v, 16, 1'b0, mon_o));
        chk("wrap16 ovf", longint'(w16.out_ovf), longint'(mon_o));
      end
    end
  end

  task automatic send(bit first, bit last, bit bv, logic [3:0] keep, logic [31:0] a, logic [31:0] b, int bias);
    int n = 0;
    bit e;
    m.in_valid = 1'b1;
    m.in_first = first;
    m.in_last = last;
    m.bias_valid = bv;
    m.in_keep = keep;
    m.a_in = a;
    m.b_in = b;
    m.bias_in = bias;
    while (!m.in_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!m.in_ready) begin
      chk("in_ready timeout", longint'(m.in_ready), 1);
      m.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    model(first, last, bv, keep, a, b, bias, e);
    #1;
    m.in_valid = 1'b0;
    chk("err_pulse", longint'(m.err_pulse), longint'(e));
  endtask

  task automatic wait_valid(string name);
    int n = 0;
    while (!m.out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({name, " valid"}, longint'(m.out_valid), 1);
  endtask

  task automatic pop_one();
    m.out_ready = 1'b1;
    @(posedge clk);
    #1;
    m.out_ready = 1'b0;
  endtask

  task automatic expect_out(string name, longint sum);
    wait_valid(name);
    chk(name, longint'(m.out_sum), lowbits(sum, 32));
    pop_one();
  endtask

  task automatic drain();
    int n = 0;
    m.out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    m.out_ready = 1'b0;
    chk("drain left", longint'(exp_q.size()), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m.in_valid = 1'b0;
    m.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    win_open = 1'b0;
  endtask

  initial begin
    int p0;
    int n;
    tbl[0] = '{4'hF, 32'h04030201, 32'h01010101, 1'b0, 0, 10};
    tbl[1] = '{4'h1, 32'h0000000A, 32'h00000005, 1'b1, 100, 150};
    tbl[2] = '{4'h0, 32'h0000000A, 32'h00000005, 1'b1, 100, 100};
    tbl[3] = '{4'hF, 32'h80808080, 32'h80808080, 1'b0, 0, 65536};
    tbl[4] = '{4'hF, 32'h80808080, 32'h7F7F7F7F, 1'b1, -5, -65029};
    tbl[5] = '{4'hA, 32'h04030201, 32'h08070605, 1'b0, 999, 44};
    m.in_first = 1'b0;
    m.in_last = 1'b0;
    m.in_keep = '0;
    m.a_in = '0;
    m.b_in = '0;
    m.bias_valid = 1'b0;
    m.bias_in = '0;
    do_reset();
    chk("reset out_valid", longint'(m.out_valid), 0);
    chk("reset in_ready", longint'(m.in_ready), 1);
    chk("reset err_pulse", longint'(m.err_pulse), 0);
    chk("reset out_sum", longint'(m.out_sum), 0);
    chk("reset out_ovf", longint'(m.out_ovf), 0);

    send(1'b1, 1'b0, 1'b0, 4'hF, 32'h04030201, 32'h01010101, 0);
    send(1'b0, 1'b1, 1'b0, 4'hF, 32'hFFFFFFFF, 32'h02020202, 0);
    chk("t1 latency k", longint'(m.out_valid), 0);
    @(posedge clk);
    #1;
    chk("t1 latency k+1", longint'(m.out_valid), 0);
    @(posedge clk);
    #1;
    chk("t1 latency k+2", longint'(m.out_valid), 1);
    expect_out("t1 sum", 2);

    for (int i = 0; i < 6; i++) begin
      send(1'b1, 1'b1, tbl[i].bv, tbl[i].keep, tbl[i].a, tbl[i].b, tbl[i].bias);
      expect_out($sformatf("tbl%0d sum", i), longint'(tbl[i].sum));
    end

    for (int i = 0; i < 8; i++) send(i == 0, i == 7, 1'b0, 4'hF, 32'h7F7F7F7F, 32'h7F7F7F7F, 0);
    wait_valid("t4");
    chk("t4 main sum", longint'(m.out_sum), 516128);
    chk("t4 main ovf", longint'(m.out_ovf), 0);
    chk("t4 sat sum", longint'(s16.out_sum), 32767);
    chk("t4 sat ovf", longint'(s16.out_ovf), 1);
    chk("t4 wrap sum", longint'(w16.out_sum), 57376);
    chk("t4 wrap ovf", longint'(w16.out_ovf), 1);
    pop_one();

    send(1'b1, 1'b0, 1'b0, 4'hF, 32'h01010101, 32'h01010101, 0);
    send(1'b1, 1'b1, 1'b0, 4'hF, 32'h02020202, 32'h03030303, 0);
    @(posedge clk);
    #1;
    chk("t5 err one cycle", longint'(m.err_pulse), 0);
    expect_out("t5 sum", 24);
    send(1'b0, 1'b1, 1'b1, 4'hF, 32'h01010101, 32'h01010101, 50);
    expect_out("t5 orphan sum", 4);

    send(1'b1, 1'b1, 1'b0, 4'h1, 32'h1, 32'h7, 0);
    send(1'b1, 1'b1, 1'b0, 4'h1, 32'h2, 32'h7, 0);
    chk("t3 ready low", longint'(m.in_ready), 0);
    p0 = pops;
    fork
      send(1'b1, 1'b1, 1'b0, 4'h1, 32'h3, 32'h7, 0);
      begin
        repeat (4) begin
          @(posedge clk);
          #1;
          chk("t3 ready held", longint'(m.in_ready), 0);
        end
        m.out_ready = 1'b1;
      end
    join
    drain();
    chk("t3 pops", longint'(pops - p0), 3);

    send(1'b1, 1'b1, 1'b0, 4'h1, 32'h1, 32'h9, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("t6 buffered", longint'(m.out_valid), 1);
    send(1'b1, 1'b0, 1'b0, 4'hF, 32'h05050505, 32'h05050505, 0);
    m.in_valid = 1'b1;
    m.in_first = 1'b0;
    m.in_last = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m.in_valid = 1'b0;
    exp_q.delete();
    win_open = 1'b0;
    chk("t6 out_valid", longint'(m.out_valid), 0);
    chk("t6 in_ready", longint'(m.in_ready), 1);
    chk("t6 out_sum", longint'(m.out_sum), 0);
    send(1'b1, 1'b0, 1'b0, 4'hF, 32'h02020202, 32'h02020202, 0);
    send(1'b0, 1'b1, 1'b0, 4'hF, 32'h01010101, 32'hFFFFFFFF, 0);
    expect_out("t6 clean sum", 12);
    chk("t6 no extra", longint'(m.out_valid), 0);

    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++)
          send($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
               4'($urandom), $urandom, $urandom, int'($urandom_range(0, 60000)) - 30000);
        done = 1'b1;
      end
      while (!done) begin
        @(posedge clk);
        #1;
        m.out_ready = $urandom_range(0, 1) == 1;
      end
    join
    drain();
    n = 0;
    while (m.out_valid && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("final empty", longint'(m.out_valid), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
